// File: rtl/dcmac_0_axis_pkt_mon_dat_chk.sv
// Payload checker for the packet monitor. It locks onto an incrementing-byte (mod 256) pattern
// in the compacted merge stream. While locked it counts checked and mismatched bytes and
// captures the first mismatch for software readout.
module dcmac_0_axis_pkt_mon_dat_chk #(
  parameter int unsigned UNLOCK_ERR = 8,
  parameter int unsigned CNT_W      = 48
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [7:0]             i_size,
  input  logic [11:0][15:0][7:0] i_dat,
  input  logic                   i_clear,
  output logic                   o_locked,
  output logic [CNT_W-1:0]       o_byte_cnt,
  output logic [CNT_W-1:0]       o_err_byte_cnt,
  output logic                   o_first_err_vld,
  output logic [7:0]             o_first_err_idx,
  output logic [7:0]             o_first_err_exp,
  output logic [7:0]             o_first_err_got,
  output logic                   o_size_ovf
);

  localparam int         NB      = 192;
  localparam logic [7:0] MaxSize = 8'd192;

  typedef enum logic {StUnlocked, StLocked} state_e;

  // Flat byte view: byte k lives at flat index k.
  logic [NB-1:0][7:0] dat_flat;
  assign dat_flat = i_dat;

  // ---------------- S1 ----------------
  logic [7:0]         s1_size_d, s1_size_q;
  logic [NB-1:0][7:0] s1_dat_q;
  logic               ovf_d, ovf_q;

  // Clamp the byte count and track the sticky oversize flag; clear wins.
  always_comb begin
    s1_size_d = (i_size > MaxSize) ? MaxSize : i_size;
    ovf_d     = ovf_q | (i_size > MaxSize);
    if (i_clear) ovf_d = 1'b0;
  end

  // ---------------- S1 compare ----------------
  state_e        state_d, state_q;
  logic [7:0]    exp_d, exp_q;
  logic [7:0]    streak_d, streak_q;
  logic [7:0]    base;
  logic [NB-1:0] mis;

  // Per-byte mismatch against the running (locked) or self-seeded (unlocked) pattern.
  always_comb begin
    base = (state_q == StLocked) ? exp_q : s1_dat_q[0];
    mis  = '0;
    for (int k = 0; k < NB; k++) begin
      mis[k] = (8'(k) < s1_size_q) && (s1_dat_q[k] != base + 8'(k));
    end
  end

  // Lock FSM next state, expected-byte tracking and error streak.
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    streak_d = streak_q;
    unique case (state_q)
      StUnlocked: begin
        if (s1_size_q != 8'd0 && mis == '0) begin
          state_d = StLocked;
          exp_d   = s1_dat_q[0] + s1_size_q;
        end
      end
      StLocked: begin
        // No resync while locked: expectation advances even on errored cycles.
        exp_d = exp_q + s1_size_q;
        if (s1_size_q != 8'd0) begin
          if (mis != '0) begin
            if (streak_q + 8'd1 >= 8'(UNLOCK_ERR)) begin
              state_d  = StUnlocked;
              streak_d = '0;
            end else begin
              streak_d = streak_q + 8'd1;
            end
          end else begin
            streak_d = '0;
          end
        end
      end
      default: state_d = StUnlocked;
    endcase
  end

  // Lock indicator output.
  always_comb begin
    o_locked = (state_q == StLocked);
  end

  // ---------------- S2 / S3 ----------------
  logic [NB-1:0]      s2_mis_q;
  logic [7:0]         s2_size_q, s2_base_q;
  logic               s2_qual_q;
  logic [NB-1:0][7:0] s2_dat_q;

  logic [7:0] pop_d, idx_d, fexp_d, fgot_d;
  logic [7:0] s3_pop_q, s3_size_q, s3_idx_q, s3_exp_q, s3_got_q;
  logic       s3_qual_q;

  // Popcount of mismatches and lowest-index priority encode with its exp/got bytes.
  always_comb begin
    pop_d = '0;
    idx_d = '0;
    for (int k = 0; k < NB; k++) begin
      pop_d = pop_d + 8'(s2_mis_q[k]);
    end
    for (int k = NB - 1; k >= 0; k--) begin
      if (s2_mis_q[k]) idx_d = 8'(k);
    end
    fexp_d = s2_base_q + idx_d;
    fgot_d = s2_dat_q[idx_d];
  end

  // ---------------- S4 ----------------
  logic [CNT_W-1:0] byte_cnt_d, byte_cnt_q, err_cnt_d, err_cnt_q;
  logic [CNT_W:0]   byte_sum, err_sum;
  logic             fe_vld_d, fe_vld_q;
  logic [7:0]       fe_idx_d, fe_idx_q, fe_exp_d, fe_exp_q, fe_got_d, fe_got_q;

  // Saturating counters and first-error capture; clear drops this cycle's contribution.
  always_comb begin
    byte_sum   = {1'b0, byte_cnt_q} + {{(CNT_W - 7){1'b0}}, s3_size_q};
    err_sum    = {1'b0, err_cnt_q} + {{(CNT_W - 7){1'b0}}, s3_pop_q};
    byte_cnt_d = byte_cnt_q;
    err_cnt_d  = err_cnt_q;
    fe_vld_d   = fe_vld_q;
    fe_idx_d   = fe_idx_q;
    fe_exp_d   = fe_exp_q;
    fe_got_d   = fe_got_q;
    if (s3_qual_q) begin
      byte_cnt_d = byte_sum[CNT_W] ? '1 : byte_sum[CNT_W-1:0];
      err_cnt_d  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
      if (s3_pop_q != 8'd0 && !fe_vld_q) begin
        fe_vld_d = 1'b1;
        fe_idx_d = s3_idx_q;
        fe_exp_d = s3_exp_q;
        fe_got_d = s3_got_q;
      end
    end
    if (i_clear) begin
      byte_cnt_d = '0;
      err_cnt_d  = '0;
      fe_vld_d   = 1'b0;
      fe_idx_d   = '0;
      fe_exp_d   = '0;
      fe_got_d   = '0;
    end
  end

  // All state and pipeline registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_size_q  <= '0;
      s1_dat_q   <= '0;
      ovf_q      <= 1'b0;
      state_q    <= StUnlocked;
      exp_q      <= '0;
      streak_q   <= '0;
      s2_mis_q   <= '0;
      s2_size_q  <= '0;
      s2_base_q  <= '0;
      s2_qual_q  <= 1'b0;
      s2_dat_q   <= '0;
      s3_pop_q   <= '0;
      s3_size_q  <= '0;
      s3_idx_q   <= '0;
      s3_exp_q   <= '0;
      s3_got_q   <= '0;
      s3_qual_q  <= 1'b0;
      byte_cnt_q <= '0;
      err_cnt_q  <= '0;
      fe_vld_q   <= 1'b0;
      fe_idx_q   <= '0;
      fe_exp_q   <= '0;
      fe_got_q   <= '0;
    end else begin
      s1_size_q  <= s1_size_d;
      s1_dat_q   <= dat_flat;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      exp_q      <= exp_d;
      streak_q   <= streak_d;
      s2_mis_q   <= mis;
      s2_size_q  <= s1_size_q;
      s2_base_q  <= base;
      s2_qual_q  <= (state_q == StLocked);
      s2_dat_q   <= s1_dat_q;
      s3_pop_q   <= pop_d;
      s3_size_q  <= s2_size_q;
      s3_idx_q   <= idx_d;
      s3_exp_q   <= fexp_d;
      s3_got_q   <= fgot_d;
      s3_qual_q  <= s2_qual_q;
      byte_cnt_q <= byte_cnt_d;
      err_cnt_q  <= err_cnt_d;
      fe_vld_q   <= fe_vld_d;
      fe_idx_q   <= fe_idx_d;
      fe_exp_q   <= fe_exp_d;
      fe_got_q   <= fe_got_d;
    end
  end

  assign o_byte_cnt      = byte_cnt_q;
  assign o_err_byte_cnt  = err_cnt_q;
  assign o_first_err_vld = fe_vld_q;
  assign o_first_err_idx = fe_idx_q;
  assign o_first_err_exp = fe_exp_q;
  assign o_first_err_got = fe_got_q;
  assign o_size_ovf      = ovf_q;

endmodule

// File: tb/tb_dcmac_0_axis_pkt_mon_dat_chk.sv
// Directed bench for the packet-monitor payload checker.
module tb_dcmac_0_axis_pkt_mon_dat_chk;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic [7:0]             size;
  logic [11:0][15:0][7:0] dat;
  logic                   clr;
  logic                   o_locked;
  logic [47:0]            o_byte_cnt, o_err_byte_cnt;
  logic                   o_first_err_vld;
  logic [7:0]             o_first_err_idx, o_first_err_exp, o_first_err_got;
  logic                   o_size_ovf;

  int n_pass   = 0;
  int n_checks = 0;
  logic [7:0] e;

  always #5 clk = ~clk;

  dcmac_0_axis_pkt_mon_dat_chk #(
    .UNLOCK_ERR(8),
    .CNT_W     (48)
  ) u_dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_size         (size),
    .i_dat          (dat),
    .i_clear        (clr),
    .o_locked       (o_locked),
    .o_byte_cnt     (o_byte_cnt),
    .o_err_byte_cnt (o_err_byte_cnt),
    .o_first_err_vld(o_first_err_vld),
    .o_first_err_idx(o_first_err_idx),
    .o_first_err_exp(o_first_err_exp),
    .o_first_err_got(o_first_err_got),
    .o_size_ovf     (o_size_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Fill with an incrementing pattern starting at start, and set the byte count.
  task automatic load_inc(input int n, input logic [7:0] start);
    for (int k = 0; k < 192; k++) dat[k / 16][k % 16] = start + 8'(k);
    size = 8'(n);
  endtask

  task automatic poke(input int k, input logic [7:0] v);
    dat[k / 16][k % 16] = v;
  endtask

  task automatic idle(input int n);
    size = 8'd0;
    repeat (n) tick();
  endtask

  initial begin
    rstn = 1'b0;
    size = 8'd0;
    dat  = '0;
    clr  = 1'b0;
    tick();
    tick();
    check("rst_locked", {63'd0, o_locked}, 64'd0);
    check("rst_cnt", {16'd0, o_byte_cnt}, 64'd0);
    rstn = 1'b1;

    // Reset and idle
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle", {o_locked, o_first_err_vld, o_size_ovf, |o_byte_cnt, |o_err_byte_cnt,
                     |o_first_err_idx, |o_first_err_exp, |o_first_err_got}, 64'd0);
    end

    // Lock and count
    load_inc(192, 8'h00); tick();
    check("lock_a_early", {63'd0, o_locked}, 64'd0);
    load_inc(100, 8'hC0); tick();
    check("lock_a", {63'd0, o_locked}, 64'd1);
    idle(2);
    check("cnt_b_early", {16'd0, o_byte_cnt}, 64'd0);
    idle(1);
    check("cnt_b", {16'd0, o_byte_cnt}, 64'd100);
    check("err_b", {16'd0, o_err_byte_cnt}, 64'd0);

    // Walk exp to 0xF0, then wrap across 0xFF
    load_inc(192, 8'h24); tick();
    load_inc(12, 8'hE4); tick();
    idle(3);
    check("pre_wrap_cnt", {16'd0, o_byte_cnt}, 64'd304);
    load_inc(32, 8'hF0); tick();
    load_inc(16, 8'h10); tick();
    idle(3);
    check("wrap_cnt", {16'd0, o_byte_cnt}, 64'd352);
    check("wrap_err", {16'd0, o_err_byte_cnt}, 64'd0);

    // Single corrupt byte at exp = 0x40
    load_inc(32, 8'h20); tick();
    load_inc(64, 8'h40); poke(5, 8'hAA); tick();
    idle(2);
    check("fe_vld_early", {63'd0, o_first_err_vld}, 64'd0);
    idle(1);
    check("c1_cnt", {16'd0, o_byte_cnt}, 64'd448);
    check("c1_err", {16'd0, o_err_byte_cnt}, 64'd1);
    check("c1_vld", {63'd0, o_first_err_vld}, 64'd1);
    check("c1_idx", {56'd0, o_first_err_idx}, 64'd5);
    check("c1_exp", {56'd0, o_first_err_exp}, 64'h45);
    check("c1_got", {56'd0, o_first_err_got}, 64'hAA);
    check("c1_locked", {63'd0, o_locked}, 64'd1);
    load_inc(16, 8'h80); poke(2, 8'h00); tick();
    load_inc(16, 8'h90); tick();
    idle(3);
    check("c2_cnt", {16'd0, o_byte_cnt}, 64'd480);
    check("c2_err", {16'd0, o_err_byte_cnt}, 64'd2);
    check("c2_idx", {56'd0, o_first_err_idx}, 64'd5);
    check("c2_got", {56'd0, o_first_err_got}, 64'hAA);

    // Streak broken by a clean cycle keeps the lock
    e = 8'hA0;
    for (int i = 0; i < 4; i++) begin
      load_inc(16, e); poke(0, ~e); tick(); e = e + 8'd16;
      idle(1);
      check("var_a_locked", {63'd0, o_locked}, 64'd1);
    end
    load_inc(16, e); tick(); e = e + 8'd16;
    for (int i = 0; i < 4; i++) begin
      load_inc(16, e); poke(0, ~e); tick(); e = e + 8'd16;
      idle(1);
      check("var_b_locked", {63'd0, o_locked}, 64'd1);
    end
    load_inc(16, e); tick(); e = e + 8'd16;
    idle(2);
    check("var_locked", {63'd0, o_locked}, 64'd1);

    // Eight errored cycles with idles interleaved
    for (int i = 1; i <= 8; i++) begin
      load_inc(16, e); poke(0, ~e); tick(); e = e + 8'd16;
      if (i == 8) check("unlock_early", {63'd0, o_locked}, 64'd1);
      idle(1);
      check("loss_locked", {63'd0, o_locked}, (i == 8) ? 64'd0 : 64'd1);
    end
    idle(3);
    check("loss_cnt", {16'd0, o_byte_cnt}, 64'd768);
    check("loss_err", {16'd0, o_err_byte_cnt}, 64'd18);

    // Relock, then oversize
    load_inc(192, 8'h00); tick();
    idle(1);
    check("relock", {63'd0, o_locked}, 64'd1);
    load_inc(200, 8'hC0); tick();
    check("ovf", {63'd0, o_size_ovf}, 64'd1);
    idle(3);
    check("ovf_cnt", {16'd0, o_byte_cnt}, 64'd960);
    check("ovf_err", {16'd0, o_err_byte_cnt}, 64'd18);

    // Clear coincident with a counter update
    load_inc(16, 8'h80); poke(3, 8'h00); tick();
    idle(2);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_cnt", {16'd0, o_byte_cnt}, 64'd0);
    check("clr_err", {16'd0, o_err_byte_cnt}, 64'd0);
    check("clr_vld", {63'd0, o_first_err_vld}, 64'd0);
    check("clr_idx", {56'd0, o_first_err_idx}, 64'd0);
    check("clr_ovf", {63'd0, o_size_ovf}, 64'd0);
    check("clr_locked", {63'd0, o_locked}, 64'd1);
    load_inc(16, 8'h90); poke(7, 8'h00); tick();
    idle(3);
    check("post_clr_cnt", {16'd0, o_byte_cnt}, 64'd16);
    check("post_clr_err", {16'd0, o_err_byte_cnt}, 64'd1);
    check("post_clr_vld", {63'd0, o_first_err_vld}, 64'd1);
    check("post_clr_idx", {56'd0, o_first_err_idx}, 64'd7);
    check("post_clr_exp", {56'd0, o_first_err_exp}, 64'h97);
    check("post_clr_got", {56'd0, o_first_err_got}, 64'h00);
    check("post_clr_locked", {63'd0, o_locked}, 64'd1);

    // Asynchronous reset mid-operation
    load_inc(16, 8'hA0); tick();
    size = 8'd0;
    rstn = 1'b0;
    #1;
    check("mid_rst_locked", {63'd0, o_locked}, 64'd0);
    check("mid_rst_cnt", {16'd0, o_byte_cnt}, 64'd0);
    check("mid_rst_vld", {63'd0, o_first_err_vld}, 64'd0);
    tick();
    rstn = 1'b1;
    idle(5);
    check("after_rst_cnt", {16'd0, o_byte_cnt}, 64'd0);
    check("after_rst_locked", {63'd0, o_locked}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dcmac_0_axis_pkt_mon_dat_chk.md
# dcmac_0_axis_pkt_mon_dat_chk

Payload checker for the packet monitor. It sits directly downstream of the monitor's data-merge stage and consumes the compacted byte stream, which is a byte count plus up to 192 left-justified valid bytes per cycle. It locks onto an incrementing-byte (mod 256) payload pattern, then counts checked and mismatched bytes. It also captures the first error for software readout.

## Interface
Parameters:
- UNLOCK_ERR, default 8: consecutive errored cycles while locked that force loss of lock (range 1..255).
- CNT_W, default 48: width of the byte counters.

Ports:
- clk  in  1  single clock for all logic.
- rstn  in  1  asynchronous, active-low reset.
- i_size  in  8  number of valid bytes in i_dat this cycle (0..192; 0 = idle).
- i_dat  in  [11:0][15:0][7:0]  merged bytes; byte k at flat index k (k < i_size valid, rest don't-care).
- i_clear  in  1  synchronous clear of counters, first-error capture and overflow flag.
- o_locked  out  1  pattern lock state.
- o_byte_cnt  out  CNT_W  bytes checked while locked (saturating).
- o_err_byte_cnt  out  CNT_W  mismatched bytes while locked (saturating).
- o_first_err_vld  out  1  first-error capture valid (sticky).
- o_first_err_idx  out  8  byte index of first mismatch.
- o_first_err_exp  out  8  expected byte at first mismatch.
- o_first_err_got  out  8  received byte at first mismatch.
- o_size_ovf  out  1  sticky: an i_size > 192 was seen.

## Operation
- S1: register i_size (clamped to 192 when > 192, which also sets o_size_ovf) and i_dat.
- S1 compare, combinational from S1 registers:
  - LOCKED: exp_k = exp + k.
  - UNLOCKED: exp_k = dat[0] + k.
  - All additions are 8-bit, wrapping mod 256.
  - mis[k] = (k < size) & (dat[k] != exp_k), for k = 0..191.
- State machine, two states, updated at the end of S1:
  - UNLOCKED:
    - size > 0 and mis == 0: go to LOCKED, exp <= dat[0] + size[7:0].
    - Otherwise stay.
    - Bytes seen in UNLOCKED, including the locking cycle, are never counted.
  - LOCKED:
    - exp <= exp + size every cycle, regardless of errors. There is no resync while locked.
    - size > 0 and mis != 0: streak++. If streak reaches UNLOCK_ERR, go to UNLOCKED and set streak to 0.
    - size > 0 and mis == 0: streak <= 0.
    - size == 0: streak unchanged.
- S2: register mis (192 b), size and the locked qualifier (the state during S1).
- S3: register popcount(mis) (0..192) and size. In the same stage, a priority encoder finds the lowest set mis index, together with its exp and got bytes.
- S4: counter update when the qualifier is set:
  - byte_cnt += size.
  - err_byte_cnt += popcount.
  - Both counters saturate at all-ones.
  - First cycle with popcount > 0 while o_first_err_vld == 0: capture idx/exp/got and set o_first_err_vld.
- i_clear:
  - Clears both counters, the first-error capture and o_size_ovf at the next edge.
  - Does not touch lock state, exp or streak.
  - Clear wins over a simultaneous S4 update. That cycle's contribution is dropped, and a capture in that cycle is also dropped.
  - Overflow detected in the same cycle as i_clear: clear wins.
- Size arithmetic: the exp update uses the clamped size modulo 256. 192 fits, so no truncation issue arises.

## Timing
- Reset state: every output 0, state UNLOCKED, exp 0, streak 0, all pipeline registers 0 (qualifier 0).
- Input at edge t:
  - S1 registered at t+1.
  - o_locked reflects that input at t+2.
  - Counters and first-error capture reflect it at t+4.
  - o_size_ovf sets at t+1.
- Fully pipelined, one input per cycle, no backpressure.
- Reset asserted mid-operation: all state returns to reset values immediately, and in-flight data is discarded.

## Test plan
1. Reset and idle:
   - Stimulus: rstn low, then i_size = 0 for 20 cycles.
   - Required: all outputs 0 throughout.
2. Lock and count:
   - Stimulus: cycle A has size 192, bytes 0x00..0xBF; cycle B has size 100, bytes 0xC0..0x23 (wrapping).
   - Required: o_locked = 1 two cycles after A; o_byte_cnt = 100 four cycles after B; o_err_byte_cnt = 0.
3. Wrap:
   - Stimulus: once locked with exp = 0xF0, send size 32 with bytes 0xF0..0xFF, 0x00..0x0F, then size 16 with bytes 0x10..0x1F.
   - Required: no errors; byte_cnt advances by 48.
4. Single corrupt byte:
   - Stimulus: locked with exp = 0x40, send size 64 with byte 5 = 0xAA.
   - Required: err_byte_cnt = 1; first_err idx = 5, exp = 0x45, got = 0xAA; o_locked remains 1.
   - Follow-up: a second corrupt cycle leaves the capture unchanged.
5. Loss of lock:
   - Stimulus: 8 errored cycles with size-0 cycles interleaved.
   - Required: o_locked drops two cycles after the 8th errored input, and not earlier.
   - Variant: the same sequence with one clean nonzero cycle after the 4th error keeps the lock.
6. Overflow and clear:
   - Stimulus: i_size = 200 while locked.
   - Required: o_size_ovf = 1; byte_cnt += 192.
   - Stimulus: i_clear asserted the same cycle as a counter update.
   - Required: counters = 0, first_err_vld = 0, ovf = 0; lock is retained.
